shift_pipe: RTL

SHIFT_PIPE -- requirements
Module: shift_pipe

---
 rtl/shift_pipe_pkg.sv | 37 +++
 rtl/shift_pipe_slice.sv | 36 +++
 rtl/shift_pipe.sv | 81 ++++++++
 3 files changed

// File: rtl/shift_pipe_pkg.sv
// Shared ALU definitions: operand/shift widths, op encodings, the op decoder
// and the combinational SLL/SRL/SRA shifter blocks.
package shift_pipe_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned ALU_SHW   = 5;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_PASS = 2'b11
  } alu_op_e;

  function automatic alu_op_e alu_op_decode(input logic [1:0] op);
    return alu_op_e'(op);
  endfunction

  function automatic logic [ALU_WIDTH-1:0] alu_sll(input logic [ALU_WIDTH-1:0] x,
                                                   input logic [ALU_SHW-1:0]   sh);
    return x << sh;
  endfunction

  function automatic logic [ALU_WIDTH-1:0] alu_srl(input logic [ALU_WIDTH-1:0] x,
                                                   input logic [ALU_SHW-1:0]   sh);
    return x >> sh;
  endfunction

  // Arithmetic right shift: vacated bits take the operand's sign bit.
  function automatic logic [ALU_WIDTH-1:0] alu_sra(input logic [ALU_WIDTH-1:0] x,
                                                   input logic [ALU_SHW-1:0]   sh);
    logic signed [ALU_WIDTH-1:0] xs;
    xs = x;
    return xs >>> sh;
  endfunction

endpackage

// File: rtl/shift_pipe_slice.sv
// pipe_slice: one valid/ready register stage of parameterised width.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake, in_data payload
//   out_valid/out_ready downstream handshake, out_data registered payload
// The stage loads whenever it is empty or its content is leaving this cycle,
// so in_ready never depends on in_valid.
module pipe_slice #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic load;

  assign load     = !out_valid || out_ready;
  assign in_ready = load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: two-stage valid/ready pipelined 32-bit shifter.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     request handshake; in_x operand, in_y shift amount
//                         (low SHW bits only), in_op 00 SLL/01 SRL/10 SRA/11 pass
//   out_valid/out_ready   result handshake; out_z registered result
//   occupancy             requests currently held (0..2)
// S1 registers the request, the shift is evaluated between S1 and S2, and S2
// registers the result, so no in_* to out_* combinational path exists.
module shift_pipe
  import shift_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned SHW   = ALU_SHW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic [1:0]       occupancy
);

  localparam int unsigned S1W = WIDTH + SHW + 2;

  logic [S1W-1:0]       s1_d;
  logic [S1W-1:0]       s1_q;
  logic                 s1_valid;
  logic                 s2_in_ready;
  logic [1:0]           s1_op;
  logic [SHW-1:0]       s1_sh;
  logic [WIDTH-1:0]     s1_x;
  logic [WIDTH-1:0]     shift_res;
  logic [WIDTH-SHW-1:0] unused_y_hi;

  // Upper shift-amount bits are ignored by definition.
  assign unused_y_hi = in_y[WIDTH-1:SHW];

  assign s1_d = {in_op, in_y[SHW-1:0], in_x};
  assign {s1_op, s1_sh, s1_x} = s1_q;

  pipe_slice #(.W(S1W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_d),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_q)
  );

  always_comb begin
    shift_res = s1_x;
    unique case (alu_op_decode(s1_op))
      OP_SLL:  shift_res = alu_sll(s1_x, s1_sh);
      OP_SRL:  shift_res = alu_srl(s1_x, s1_sh);
      OP_SRA:  shift_res = alu_sra(s1_x, s1_sh);
      OP_PASS: shift_res = s1_x;
    endcase
  end

  pipe_slice #(.W(WIDTH)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (shift_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_z)
  );

  assign occupancy = {1'b0, s1_valid} + {1'b0, out_valid};

endmodule
